// File: rtl/dcache_pkg.sv
// ----------------------------------------------------------------------------
// dcache_pkg
// Shared definitions for the 2-way write-back data cache:
//   - miss-handling FSM state encoding
//   - default cache geometry and the address-field widths derived from it
//   - a generic address field-extract helper
// No ports (package).
// ----------------------------------------------------------------------------
package dcache_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EVICT,
      ST_REQ,
      ST_WAIT,
      ST_ALLOC
   } state_e;

   // Default geometry; the top module recomputes its own widths from its
   // parameters, these describe the default build.
   localparam int unsigned ADDR_W         = 32;
   localparam int unsigned DATA_W         = 32;
   localparam int unsigned WORDS_PER_LINE = 8;
   localparam int unsigned NUM_SETS       = 64;

   localparam int unsigned BYTE_W   = $clog2(DATA_W / 8);
   localparam int unsigned OFFSET_W = $clog2(WORDS_PER_LINE);
   localparam int unsigned INDEX_W  = $clog2(NUM_SETS);
   localparam int unsigned TAG_W    = ADDR_W - BYTE_W - OFFSET_W - INDEX_W;
   localparam int unsigned LINE_W   = DATA_W * WORDS_PER_LINE;

   // Returns addr[lsb +: width], zero-extended to 64 bits.
   function automatic logic [63:0] addr_field(input logic [63:0]   addr,
                                              input int unsigned   lsb,
                                              input int unsigned   width);
      logic [63:0] mask;
      mask = (width >= 64) ? '1 : ((64'd1 << width) - 64'd1);
      return (addr >> lsb) & mask;
   endfunction

endpackage

// File: rtl/dcache_merge.sv
// ----------------------------------------------------------------------------
// dcache_merge
// Combinational byte-merge of one CPU word into a cache line.
// Ports:
//   word_off  in   word select within the line
//   byte_en   in   per-byte write enables for the selected word
//   wdata     in   store data
//   line_in   in   original line
//   line_out  out  line with the enabled bytes of wdata written into word_off
// ----------------------------------------------------------------------------
module dcache_merge #(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned WORDS_PER_LINE = 8
) (
   input  logic [$clog2(WORDS_PER_LINE)-1:0]    word_off,
   input  logic [DATA_W/8-1:0]                  byte_en,
   input  logic [DATA_W-1:0]                    wdata,
   input  logic [DATA_W*WORDS_PER_LINE-1:0]     line_in,
   output logic [DATA_W*WORDS_PER_LINE-1:0]     line_out
);

   always_comb begin
      // NOTE: every always_comb output gets a default first; a path that
      // leaves it unassigned would infer a latch.
      line_out = line_in;
      for (int b = 0; b < DATA_W / 8; b++) begin
         if (byte_en[b]) begin
            line_out[DATA_W * int'(word_off) + 8 * b +: 8] = wdata[8 * b +: 8];
         end
      end
   end

endmodule

// File: rtl/dcache_wb_2way.sv
// ----------------------------------------------------------------------------
// dcache_wb_2way
// 2-way set-associative, write-back, write-allocate data cache with one LRU
// bit per set and a five-state miss FSM (IDLE/EVICT/REQ/WAIT/ALLOC).
// Ports:
//   Clk, Rst_n                    clock / asynchronous active-low reset
//   En, RW, ByteEn, Address,
//   WData                         CPU request (RW=1 store, ByteEn per byte)
//   RData, Stall                  load data (valid when En&~RW&~Stall), stall
//   WB_Valid/WB_Ready/WB_Addr/
//   WB_Line                       dirty-victim write-back handshake
//   Fill_Req/Fill_ReqReady/
//   Fill_Addr                     refill request handshake
//   Fill_Valid/Fill_Line          refill data (one-cycle pulse, word 0 in LSBs)
// ----------------------------------------------------------------------------
module dcache_wb_2way
   import dcache_pkg::*;
#(
   parameter int unsigned ADDR_W         = 32,
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned WORDS_PER_LINE = 8,
   parameter int unsigned NUM_SETS       = 64
) (
   input  logic                               Clk,
   input  logic                               Rst_n,
   input  logic                               En,
   input  logic                               RW,
   input  logic [DATA_W/8-1:0]                ByteEn,
   input  logic [ADDR_W-1:0]                  Address,
   input  logic [DATA_W-1:0]                  WData,
   output logic [DATA_W-1:0]                  RData,
   output logic                               Stall,
   output logic                               WB_Valid,
   input  logic                               WB_Ready,
   output logic [ADDR_W-1:0]                  WB_Addr,
   output logic [DATA_W*WORDS_PER_LINE-1:0]   WB_Line,
   output logic                               Fill_Req,
   input  logic                               Fill_ReqReady,
   output logic [ADDR_W-1:0]                  Fill_Addr,
   input  logic                               Fill_Valid,
   input  logic [DATA_W*WORDS_PER_LINE-1:0]   Fill_Line
);

   localparam int unsigned BE_BITS     = DATA_W / 8;
   localparam int unsigned BYTE_BITS   = $clog2(BE_BITS);
   localparam int unsigned OFFSET_BITS = $clog2(WORDS_PER_LINE);
   localparam int unsigned INDEX_BITS  = $clog2(NUM_SETS);
   localparam int unsigned LINE_LSB    = BYTE_BITS + OFFSET_BITS;
   localparam int unsigned TAG_BITS    = ADDR_W - LINE_LSB - INDEX_BITS;
   localparam int unsigned LINE_BITS   = DATA_W * WORDS_PER_LINE;

   // ---------------- storage ----------------
   logic [NUM_SETS-1:0]  valid_q [2];
   logic [NUM_SETS-1:0]  dirty_q [2];
   logic [NUM_SETS-1:0]  lru_q;
   logic [TAG_BITS-1:0]  tag_q   [2][NUM_SETS];
   logic [LINE_BITS-1:0] data_q  [2][NUM_SETS];

   // ---------------- FSM and latched miss context ----------------
   state_e               state_q, state_d;
   logic                 victim_q, victim_d;
   logic [ADDR_W-1:0]    wb_addr_q, wb_addr_d;
   logic [LINE_BITS-1:0] wb_line_q, wb_line_d;
   logic [ADDR_W-1:0]    fill_addr_q, fill_addr_d;
   logic [LINE_BITS-1:0] fill_line_q, fill_line_d;
   logic                 lat_rw_q, lat_rw_d;
   logic [ADDR_W-1:0]    lat_addr_q, lat_addr_d;
   logic [DATA_W-1:0]    lat_wdata_q, lat_wdata_d;
   logic [BE_BITS-1:0]   lat_be_q, lat_be_d;

   // ---------------- address decode ----------------
   logic [OFFSET_BITS-1:0] req_off, lat_off;
   logic [INDEX_BITS-1:0]  req_idx, lat_idx;
   logic [TAG_BITS-1:0]    req_tag, lat_tag;

   assign req_off = OFFSET_BITS'(addr_field(64'(Address), BYTE_BITS, OFFSET_BITS));
   assign req_idx = INDEX_BITS'(addr_field(64'(Address), LINE_LSB, INDEX_BITS));
   assign req_tag = TAG_BITS'(addr_field(64'(Address), LINE_LSB + INDEX_BITS, TAG_BITS));
   assign lat_off = OFFSET_BITS'(addr_field(64'(lat_addr_q), BYTE_BITS, OFFSET_BITS));
   assign lat_idx = INDEX_BITS'(addr_field(64'(lat_addr_q), LINE_LSB, INDEX_BITS));
   assign lat_tag = TAG_BITS'(addr_field(64'(lat_addr_q), LINE_LSB + INDEX_BITS, TAG_BITS));

   // ---------------- lookup ----------------
   // Gating the request with Rst_n makes Stall drop in the same instant the
   // asynchronous reset clears the FSM, even if the CPU keeps En high.
   logic                 en_live;
   logic [1:0]           way_hit;
   logic                 hit, hit_way;
   logic [LINE_BITS-1:0] hit_line;
   logic                 victim_way, victim_dirty;

   assign en_live      = En & Rst_n;
   assign way_hit[0]   = valid_q[0][req_idx] && (tag_q[0][req_idx] == req_tag);
   assign way_hit[1]   = valid_q[1][req_idx] && (tag_q[1][req_idx] == req_tag);
   assign hit          = en_live & (|way_hit);
   assign hit_way      = way_hit[1];
   assign hit_line     = data_q[hit_way][req_idx];
   assign victim_way   = lru_q[req_idx];
   assign victim_dirty = valid_q[victim_way][req_idx] & dirty_q[victim_way][req_idx];

   always_comb begin
      RData = '0;
      if (state_q == ST_IDLE && hit && !RW) begin
         RData = hit_line[DATA_W * int'(req_off) +: DATA_W];
      end
   end

   // ---------------- byte merge (write hit / write-miss allocate) ----------
   logic                   alloc;
   logic [OFFSET_BITS-1:0] mrg_off;
   logic [BE_BITS-1:0]     mrg_be;
   logic [DATA_W-1:0]      mrg_wdata;
   logic [LINE_BITS-1:0]   mrg_line_in, merged_line;

   assign alloc       = (state_q == ST_ALLOC);
   assign mrg_off     = alloc ? lat_off     : req_off;
   assign mrg_be      = alloc ? lat_be_q    : ByteEn;
   assign mrg_wdata   = alloc ? lat_wdata_q : WData;
   assign mrg_line_in = alloc ? fill_line_q : hit_line;

   dcache_merge #(
      .DATA_W         (DATA_W),
      .WORDS_PER_LINE (WORDS_PER_LINE)
   ) u_merge (
      .word_off (mrg_off),
      .byte_en  (mrg_be),
      .wdata    (mrg_wdata),
      .line_in  (mrg_line_in),
      .line_out (merged_line)
   );

   // ---------------- next state / array write port ----------------
   logic                   arr_we, arr_way, arr_dirty;
   logic [INDEX_BITS-1:0]  arr_idx;
   logic [TAG_BITS-1:0]    arr_tag;
   logic [LINE_BITS-1:0]   arr_line;
   logic                   lru_we, lru_val;
   logic [INDEX_BITS-1:0]  lru_idx;

   always_comb begin
      state_d     = state_q;
      victim_d    = victim_q;
      wb_addr_d   = wb_addr_q;
      wb_line_d   = wb_line_q;
      fill_addr_d = fill_addr_q;
      fill_line_d = fill_line_q;
      lat_rw_d    = lat_rw_q;
      lat_addr_d  = lat_addr_q;
      lat_wdata_d = lat_wdata_q;
      lat_be_d    = lat_be_q;
      Stall       = 1'b0;
      WB_Valid    = 1'b0;
      Fill_Req    = 1'b0;
      arr_we      = 1'b0;
      arr_way     = hit_way;
      arr_idx     = req_idx;
      arr_tag     = req_tag;
      arr_line    = merged_line;
      arr_dirty   = 1'b1;
      lru_we      = 1'b0;
      lru_idx     = req_idx;
      lru_val     = ~hit_way;

      case (state_q)
         ST_IDLE: begin
            if (en_live) begin
               if (hit) begin
                  lru_we = 1'b1;
                  arr_we = RW;      // write hit: merged line, dirty set
               end else begin
                  Stall       = 1'b1;
                  lat_rw_d    = RW;
                  lat_addr_d  = Address;
                  lat_wdata_d = WData;
                  lat_be_d    = ByteEn;
                  victim_d    = victim_way;
                  fill_addr_d = {req_tag, req_idx, {LINE_LSB{1'b0}}};
                  if (victim_dirty) begin
                     wb_addr_d = {tag_q[victim_way][req_idx], req_idx, {LINE_LSB{1'b0}}};
                     wb_line_d = data_q[victim_way][req_idx];
                     state_d   = ST_EVICT;
                  end else begin
                     state_d   = ST_REQ;
                  end
               end
            end
         end
         ST_EVICT: begin
            Stall    = 1'b1;
            WB_Valid = 1'b1;
            if (WB_Ready) state_d = ST_REQ;
         end
         ST_REQ: begin
            Stall    = 1'b1;
            Fill_Req = 1'b1;
            if (Fill_ReqReady) state_d = ST_WAIT;
         end
         ST_WAIT: begin
            Stall = 1'b1;
            if (Fill_Valid) begin
               fill_line_d = Fill_Line;
               state_d     = ST_ALLOC;
            end
         end
         ST_ALLOC: begin
            Stall     = 1'b1;
            arr_we    = 1'b1;
            arr_way   = victim_q;
            arr_idx   = lat_idx;
            arr_tag   = lat_tag;
            arr_line  = lat_rw_q ? merged_line : fill_line_q;
            arr_dirty = lat_rw_q;
            lru_we    = 1'b1;
            lru_idx   = lat_idx;
            lru_val   = ~victim_q;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign WB_Addr   = wb_addr_q;
   assign WB_Line   = wb_line_q;
   assign Fill_Addr = fill_addr_q;

   // ---------------- control state (reset) ----------------
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         // NOTE: sequential state uses non-blocking assignments so every flop
         // samples pre-edge values regardless of statement order.
         state_q     <= ST_IDLE;
         victim_q    <= 1'b0;
         wb_addr_q   <= '0;
         wb_line_q   <= '0;
         fill_addr_q <= '0;
         valid_q[0]  <= '0;
         valid_q[1]  <= '0;
         dirty_q[0]  <= '0;
         dirty_q[1]  <= '0;
         lru_q       <= '0;
      end else begin
         state_q     <= state_d;
         victim_q    <= victim_d;
         wb_addr_q   <= wb_addr_d;
         wb_line_q   <= wb_line_d;
         fill_addr_q <= fill_addr_d;
         if (arr_we) begin
            valid_q[arr_way][arr_idx] <= 1'b1;
            dirty_q[arr_way][arr_idx] <= arr_dirty;
         end
         if (lru_we) lru_q[lru_idx] <= lru_val;
      end
   end

   // ---------------- datapath storage (no reset) ----------------
   // NOTE: tag/data arrays and the latched request are deliberately not
   // reset; valid bits qualify them, and resetting them would block RAM
   // inference.
   always_ff @(posedge Clk) begin
      fill_line_q <= fill_line_d;
      lat_rw_q    <= lat_rw_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      lat_be_q    <= lat_be_d;
      if (arr_we) begin
         tag_q[arr_way][arr_idx]  <= arr_tag;
         data_q[arr_way][arr_idx] <= arr_line;
      end
   end

endmodule
